// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, pad bytes and FSM states for the Keccak padder.
// KECCAK_PAD_SHA3_EN selects the SHA-3 domain byte 8'h06 instead of Keccak 8'h01.
package keccak_pkg;
  localparam int KECCAK_WORD_W = 64;
  localparam int KECCAK_BLK_W = 512;
`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] PAD_FIRST_BYTE = 8'h06;
`else
  localparam logic [7:0] PAD_FIRST_BYTE = 8'h01;
`endif
  localparam logic [7:0] PAD_LAST_BYTE = 8'h80;
  typedef enum logic [1:0] {ACCEPT, PAD, FULL} state_e;
endpackage

// File: rtl/keccak_pad_word.sv
// keccak_pad_word: applies pad10*1 to the final partial word; passes other words through.
module keccak_pad_word
  import keccak_pkg::*;
(
  input  logic [KECCAK_WORD_W-1:0] in_word_i,
  input  logic [2:0]               byte_num_i,
  input  logic                     is_last_i,
  input  logic                     is_word7_i,
  output logic [KECCAK_WORD_W-1:0] pad_word_o
);
  logic [5:0]               sh;
  logic [KECCAK_WORD_W-1:0] mask, first, closing;
  assign sh = {byte_num_i, 3'b000};
  assign mask = (64'd1 << sh) - 64'd1;
  assign first = {56'd0, PAD_FIRST_BYTE} << sh;
  // the closing 0x80 merges with the domain byte when both land in byte 7
  assign closing = is_word7_i ? {PAD_LAST_BYTE, 56'd0} : '0;
  assign pad_word_o = is_last_i ? (in_word_i & mask) | first | closing : in_word_i;
endmodule

// File: rtl/keccak_padder_512.sv
// keccak_padder_512: packs 64-bit words into padded 512-bit blocks with a valid/ack handshake.
// Build option: KECCAK_PAD_SHA3_EN (SHA-3 domain pad byte).
module keccak_padder_512
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [KECCAK_WORD_W-1:0] in_word,
  input  logic                     in_ready,
  input  logic                     is_last,
  input  logic [2:0]               byte_num,
  input  logic                     out_ack,
  output logic                     busy,
  output logic [KECCAK_BLK_W-1:0]  out_blk,
  output logic                     out_valid,
  output logic                     out_last
);
  state_e                   state_q;
  logic [2:0]               cnt_q;
  logic                     last_q;
  logic [KECCAK_BLK_W-1:0]  blk_q;
  logic [KECCAK_WORD_W-1:0] pad_w, word_d;
  keccak_pad_word u_pad (
    .in_word_i (in_word),
    .byte_num_i(byte_num),
    .is_last_i (is_last),
    .is_word7_i(&cnt_q),
    .pad_word_o(pad_w)
  );
  assign word_d = state_q == PAD ? (&cnt_q ? {PAD_LAST_BYTE, 56'd0} : '0) : pad_w;
  // the 3-bit counter wraps to 0 on word 7; FULL acts as the full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCEPT;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      blk_q   <= '0;
    end else begin
      case (state_q)
        ACCEPT: if (in_ready) begin
          blk_q[{cnt_q, 6'b0} +: KECCAK_WORD_W] <= word_d;
          cnt_q <= cnt_q + 3'd1;
          if (is_last) last_q <= 1'b1;
          if (&cnt_q) state_q <= FULL;
          else if (is_last) state_q <= PAD;
        end
        PAD: begin
          blk_q[{cnt_q, 6'b0} +: KECCAK_WORD_W] <= word_d;
          cnt_q <= cnt_q + 3'd1;
          if (&cnt_q) state_q <= FULL;
        end
        FULL: if (out_ack) begin
          state_q <= ACCEPT;
          last_q  <= 1'b0;
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end
  assign busy = state_q != ACCEPT;
  assign out_valid = state_q == FULL;
  assign out_last = state_q == FULL && last_q;
  assign out_blk = blk_q;
endmodule

// File: tb/tb_keccak_padder_512.sv
// tb_keccak_padder_512: directed checks of packing, padding, handshake and async reset.
module tb_keccak_padder_512;
`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] PF = 8'h06;
`else
  localparam logic [7:0] PF = 8'h01;
`endif
  localparam logic [63:0] BASE = 64'h0706050403020100;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [63:0]  in_word = '0;
  logic         in_ready = 1'b0, is_last = 1'b0, out_ack = 1'b0;
  logic [2:0]   byte_num = '0;
  logic         busy, out_valid, out_last;
  logic [511:0] out_blk, exp_blk;
  int           n_vec = 0, n_err = 0, cyc;
  always #5 clk = ~clk;
  keccak_padder_512 dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_ready(in_ready), .is_last(is_last),
    .byte_num(byte_num), .out_ack(out_ack), .busy(busy), .out_blk(out_blk),
    .out_valid(out_valid), .out_last(out_last)
  );
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [63:0] w, input logic l, input logic [2:0] bn);
    in_word = w; is_last = l; byte_num = bn; in_ready = 1'b1;
    step();
    in_ready = 1'b0; is_last = 1'b0; byte_num = '0;
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask
  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_last", 512'(out_last), 512'(0));
    chk("rst_blk", out_blk, '0);
    rst = 1'b1;
    step();
    // 1) eight full words
    exp_blk = '0;
    for (int i = 0; i < 8; i++) begin
      put(BASE + 64'(i), 1'b0, 3'd0);
      exp_blk[i*64 +: 64] = BASE + 64'(i);
      if (i == 6) chk("t1_busy_pre", 512'(busy), 512'(0));
    end
    chk("t1_valid", 512'(out_valid), 512'(1));
    chk("t1_blk", out_blk, exp_blk);
    chk("t1_last", 512'(out_last), 512'(0));
    chk("t1_busy", 512'(busy), 512'(1));
    ack();
    chk("t1_valid_ack", 512'(out_valid), 512'(0));
    chk("t1_busy_ack", 512'(busy), 512'(0));
    // 2) partial last word at word 3, junk offered during PAD and FULL
    exp_blk = '0;
    for (int i = 0; i < 3; i++) begin
      put(64'h1000 + 64'(i), 1'b0, 3'd0);
      exp_blk[i*64 +: 64] = 64'h1000 + 64'(i);
    end
    put(64'hAABB, 1'b1, 3'd2);
    exp_blk[3*64 +: 64] = {40'd0, PF, 16'hAABB};
    exp_blk[7*64 +: 64] = 64'h8000_0000_0000_0000;
    chk("t2_busy_pad", 512'(busy), 512'(1));
    in_word = 64'hDEAD_BEEF_DEAD_BEEF; in_ready = 1'b1; is_last = 1'b1;
    wait_valid(cyc);
    chk("t2_latency", 512'(cyc), 512'(5));
    chk("t2_blk", out_blk, exp_blk);
    chk("t2_last", 512'(out_last), 512'(1));
    for (int i = 0; i < 20; i++) step();
    in_ready = 1'b0; is_last = 1'b0;
    chk("t5_hold_valid", 512'(out_valid), 512'(1));
    chk("t5_hold_blk", out_blk, exp_blk);
    ack();
    chk("t2_last_ack", 512'(out_last), 512'(0));
    // 3) byte_num=7 in word 7 merges domain and closing bytes; high junk byte masked
    exp_blk = '0;
    for (int i = 0; i < 7; i++) begin
      put(64'h0101010101010101 * 64'(i + 1), 1'b0, 3'd0);
      exp_blk[i*64 +: 64] = 64'h0101010101010101 * 64'(i + 1);
    end
    put(64'hEE11223344556677, 1'b1, 3'd7);
    exp_blk[7*64 +: 64] = {PF | 8'h80, 56'h11223344556677};
    chk("t3_valid", 512'(out_valid), 512'(1));
    chk("t3_blk", out_blk, exp_blk);
    chk("t3_last", 512'(out_last), 512'(1));
    ack();
    // 4) empty message; a stray ack beforehand is ignored
    ack();
    chk("t4_busy_idle", 512'(busy), 512'(0));
    put(64'hDEADBEEF_CAFEF00D, 1'b1, 3'd0);
    exp_blk = '0;
    exp_blk[63:0] = {56'd0, PF};
    exp_blk[7*64 +: 64] = 64'h8000_0000_0000_0000;
    wait_valid(cyc);
    chk("t4_latency", 512'(cyc), 512'(8));
    chk("t4_blk", out_blk, exp_blk);
    chk("t4_last", 512'(out_last), 512'(1));
    ack();
    // 6) async reset mid-block, then a clean block
    for (int i = 0; i < 4; i++) put(64'h5555 + 64'(i), 1'b0, 3'd0);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_blk", out_blk, '0);
    chk("t6_rst_busy", 512'(busy), 512'(0));
    chk("t6_rst_valid", 512'(out_valid), 512'(0));
    #2 rst = 1'b1;
    step();
    exp_blk = '0;
    for (int i = 0; i < 8; i++) begin
      put(~(BASE + 64'(i)), 1'b0, 3'd0);
      exp_blk[i*64 +: 64] = ~(BASE + 64'(i));
    end
    chk("t6_valid", 512'(out_valid), 512'(1));
    chk("t6_blk", out_blk, exp_blk);
    chk("t6_last", 512'(out_last), 512'(0));
    ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
